// File: rtl/jelly_alpha_pkg.sv
// Shared constants and helpers for the jelly alpha blend/unblend math blocks.
package jelly_alpha_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic int unsigned alpha_max(input int unsigned alpha_width);
    return (32'd1 << alpha_width) - 32'd1;
  endfunction

  // One quotient bit per dividend bit, so the iteration count equals the dividend width.
  function automatic int unsigned unblend_iterations(input int unsigned alpha_width,
                                                     input int unsigned data_width);
    return alpha_width + data_width;
  endfunction

endpackage

// File: rtl/jelly_unsigned_iterative_divider.sv
// Restoring unsigned divider: one quotient bit per enabled cycle after start.
module jelly_unsigned_iterative_divider #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_WIDTH - 1);

  logic [DIVISOR_WIDTH:0]    rem_q, rem_d, trial_s;
  logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
  logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d, done_q, done_d;

  // The quotient register doubles as the dividend shifter: MSB feeds the remainder, new bit enters at LSB.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    trial_s   = (rem_q << 1) | {{DIVISOR_WIDTH{1'b0}}, quo_q[DIVIDEND_WIDTH-1]};
    if (start) begin
      rem_d     = '0;
      quo_d     = dividend;
      divisor_d = divisor;
      cnt_d     = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (trial_s >= {1'b0, divisor_q}) begin
        rem_d = trial_s - {1'b0, divisor_q};
        quo_d = {quo_q[DIVIDEND_WIDTH-2:0], 1'b1};
      end else begin
        rem_d = trial_s;
        quo_d = {quo_q[DIVIDEND_WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (cke) begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/jelly_unsigned_alpha_unblend.sv
// Recovers foreground d0 from blended m, background d1 and alpha a (inverse alpha blend).
// Define JELLY_UNSIGNED_ALPHA_UNBLEND_ROUND_EN for round-half-up instead of truncation.
module jelly_unsigned_alpha_unblend
  import jelly_alpha_pkg::*;
#(
  parameter int ALPHA_WIDTH = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 0,
  localparam int USER_BITS  = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cke,
  input  logic [ALPHA_WIDTH-1:0] s_alpha,
  input  logic [DATA_WIDTH-1:0]  s_blend,
  input  logic [DATA_WIDTH-1:0]  s_data1,
  input  logic [USER_BITS-1:0]   s_user,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [USER_BITS-1:0]   m_user,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int Q_W   = unblend_iterations(ALPHA_WIDTH, DATA_WIDTH);
  localparam int NUM_W = Q_W + 1;
  localparam logic [ALPHA_WIDTH-1:0] AMAX_V = ALPHA_WIDTH'(alpha_max(ALPHA_WIDTH));

  logic [1:0]             state_q, state_d;
  logic [ALPHA_WIDTH-1:0] alpha_q, alpha_d;
  logic [DATA_WIDTH-1:0]  blend_q, blend_d, data1_q, data1_d;
  logic [USER_BITS-1:0]   user_q, user_d;
  logic                   m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
  logic [USER_BITS-1:0]   m_user_q, m_user_d;

  logic [NUM_W-1:0]       num_s;
  logic [Q_W-1:0]         dividend_s, quo_s;
  logic [DATA_WIDTH-1:0]  result_s;
  logic                   div_start_s, div_busy_s, div_done_s;

  // Numerator m*AMAX - d1*(AMAX-a); two's complement, non-positive values clamp to a zero dividend.
  always_comb begin
    num_s = NUM_W'(blend_q) * NUM_W'(AMAX_V) - NUM_W'(data1_q) * NUM_W'(AMAX_V - alpha_q);
    if (!num_s[NUM_W-1] && (num_s != '0)) begin
`ifdef JELLY_UNSIGNED_ALPHA_UNBLEND_ROUND_EN
      dividend_s = num_s[Q_W-1:0] + Q_W'(alpha_q >> 1);
`else
      dividend_s = num_s[Q_W-1:0];
`endif
    end else begin
      dividend_s = '0;
    end
  end

  assign div_start_s = (state_q == ST_CALC);

  jelly_unsigned_iterative_divider #(
    .DIVIDEND_WIDTH (Q_W),
    .DIVISOR_WIDTH  (ALPHA_WIDTH)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .start    (div_start_s),
    .dividend (dividend_s),
    .divisor  (alpha_q),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (quo_s)
  );

  // Zero alpha carries no foreground information; otherwise saturate on quotient overflow.
  always_comb begin
    if (alpha_q == '0) begin
      result_s = '0;
    end else if (|quo_s[Q_W-1:DATA_WIDTH]) begin
      result_s = '1;
    end else begin
      result_s = quo_s[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    alpha_d   = alpha_q;
    blend_d   = blend_q;
    data1_d   = data1_q;
    user_d    = user_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          alpha_d = s_alpha;
          blend_d = s_blend;
          data1_d = s_data1;
          user_d  = s_user;
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: state_d = ST_DIV;
      ST_DIV: begin
        if (div_done_s && !div_busy_s) begin
          m_valid_d = 1'b1;
          m_data_d  = result_s;
          m_user_d  = user_q;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      alpha_q   <= '0;
      blend_q   <= '0;
      data1_q   <= '0;
      user_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
    end else if (cke) begin
      state_q   <= state_d;
      alpha_q   <= alpha_d;
      blend_q   <= blend_d;
      data1_q   <= data1_d;
      user_q    <= user_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_user_q  <= m_user_d;
    end
  end

  assign s_ready = (state_q == ST_IDLE) && !reset;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_user  = m_user_q;

endmodule

// File: tb/tb_jelly_unsigned_alpha_unblend.sv
// Self-checking bench for jelly_unsigned_alpha_unblend (8-bit alpha/data, 4-bit user).
module tb_jelly_unsigned_alpha_unblend;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int UW = 4;
  localparam int LATENCY = AW + DW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke = 1'b1;
  logic [AW-1:0] s_alpha = '0;
  logic [DW-1:0] s_blend = '0;
  logic [DW-1:0] s_data1 = '0;
  logic [UW-1:0] s_user = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [UW-1:0] m_user;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  jelly_unsigned_alpha_unblend #(
    .ALPHA_WIDTH (AW),
    .DATA_WIDTH  (DW),
    .USER_WIDTH  (UW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .s_alpha (s_alpha),
    .s_blend (s_blend),
    .s_data1 (s_data1),
    .s_user  (s_user),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_user  (m_user),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Solve m = (d0*a + d1*(AMAX-a)) / AMAX for d0 with integer arithmetic.
  function automatic int ref_unblend(input int a, input int m, input int d1);
    int amax;
    int num;
    int q;
    amax = (1 << AW) - 1;
    if (a == 0) return 0;
    num = m * amax - d1 * (amax - a);
    if (num <= 0) return 0;
`ifdef JELLY_UNSIGNED_ALPHA_UNBLEND_ROUND_EN
    num = num + a / 2;
`endif
    q = num / a;
    return (q > (1 << DW) - 1) ? (1 << DW) - 1 : q;
  endfunction

  task automatic run_txn(input string tag, input int a, input int m, input int d1, input int u,
                         input int stall, input int hold, input int exp_data);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    s_alpha = AW'(a);
    s_blend = DW'(m);
    s_data1 = DW'(d1);
    s_user  = UW'(u);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 200) begin
      cke = (lat >= 5 && lat < 5 + stall) ? 1'b0 : 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    cke = 1'b1;
    check_val({tag, "_latency"}, 32'(lat), 32'(LATENCY + stall));
    check_val({tag, "_data"}, 32'(m_data), 32'(exp_data));
    check_val({tag, "_user"}, 32'(m_user), 32'(u & ((1 << UW) - 1)));
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) begin
      check_val({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
      check_val({tag, "_hold_data"}, 32'(m_data), 32'(exp_data));
      check_val({tag, "_hold_user"}, 32'(m_user), 32'(u & ((1 << UW) - 1)));
      check_val({tag, "_hold_s_ready"}, 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_post_valid"}, 32'(m_valid), 32'd0);
    check_val({tag, "_post_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    int a;
    int m;
    int d1;
    int u;
    int stray;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'd0);
    check_val("rst_m_user", 32'(m_user), 32'd0);
    check_val("rst_s_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rel_s_ready", 32'(s_ready), 32'd1);

    run_txn("a255", 255, 100, 50, 5, 0, 0, 100);
    run_txn("a128_eq", 128, 100, 100, 6, 0, 0, 100);
    run_txn("neg_num", 128, 0, 255, 7, 0, 0, 0);
    run_txn("saturate", 1, 255, 0, 8, 0, 0, 255);
    run_txn("alpha0", 0, 200, 30, 9, 0, 0, 0);
`ifdef JELLY_UNSIGNED_ALPHA_UNBLEND_ROUND_EN
    run_txn("round", 2, 1, 0, 10, 0, 0, 128);
`else
    run_txn("round", 2, 1, 0, 10, 0, 0, 127);
`endif
    run_txn("hold", 200, 150, 20, 11, 0, 10, ref_unblend(200, 150, 20));
    run_txn("stall", 100, 60, 90, 12, 4, 0, ref_unblend(100, 60, 90));

    // Abandon a division part way through with a reset.
    @(negedge clk);
    s_alpha = 8'd255;
    s_blend = 8'd50;
    s_data1 = 8'd0;
    s_user  = 4'd3;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_m_valid", 32'(m_valid), 32'd0);
    check_val("midrst_s_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("midrst_rel_s_ready", 32'(s_ready), 32'd1);
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (m_valid) stray++;
    end
    check_val("midrst_no_stray_valid", 32'(stray), 32'd0);
    run_txn("rst_next", 255, 7, 0, 13, 0, 0, 7);

    for (int i = 0; i < 20; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
      m  = int'($urandom_range(0, 255));
      d1 = int'($urandom_range(0, 255));
      u  = int'($urandom_range(0, 15));
      run_txn($sformatf("rnd%0d", i), a, m, d1, u, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)), ref_unblend(a, m, d1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
